pokey_bus_sequencer: RTL and testbench



---
 rtl/pokey_bus_pkg.sv | 12 +
 rtl/m_counter.sv | 15 +
 rtl/pokey_req_fifo.sv | 34 +++
 rtl/pokey_bus_sequencer.sv | 88 ++++++++
 tb/tb_pokey_bus_sequencer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/pokey_bus_pkg.sv
// pokey_bus_pkg: request entry type, sequencer states and POKEY register addresses
package pokey_bus_pkg;
  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] data;
  } pokeyReq_t;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [3:0] AUDF1 = 4'h0, AUDC1 = 4'h1, AUDF2 = 4'h2, AUDC2 = 4'h3;
  localparam logic [3:0] AUDF3 = 4'h4, AUDC3 = 4'h5, AUDF4 = 4'h6, AUDC4 = 4'h7;
  localparam logic [3:0] AUDCTL = 4'h8, ALLPOT = 4'h8, RANDOM = 4'hA, POTGO = 4'hB, SKCTL = 4'hF;
endpackage

// File: rtl/m_counter.sv
// m_counter: free-running modulo-MOD counter; tick is high on the last count (clk, clr in; tick out)
module m_counter #(
  parameter int MOD = 33
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(MOD);
  logic [W-1:0] count;
  assign tick = count == W'(MOD - 1);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else     count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/pokey_req_fifo.sv
// pokey_req_fifo: synchronous FIFO of pokeyReq_t (push/din in, pop in, head/count out); push refused while full
module pokey_req_fifo
  import pokey_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      push,
  input  pokeyReq_t din,
  input  logic      pop,
  output pokeyReq_t head,
  output logic [AW:0] count
);
  pokeyReq_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count < (AW+1)'(DEPTH);
  assign do_pop  = pop && count != '0;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/pokey_bus_sequencer.sv
// pokey_bus_sequencer: buffers CPU register requests and replays them on POKEY pins at the phi2 rate
//   clk/clr                       : system clock, sync active-high reset
//   reqValid/reqReady/reqWrite/reqAddr/reqData : request handshake into the FIFO
//   rspValid/rspData              : one-cycle read-data pulse
//   phi2/cs0Bar/readHighWriteLow/A/Din/Dout    : POKEY chip pins
//   fifoCount                     : FIFO occupancy
module pokey_bus_sequencer
  import pokey_bus_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PHI2_HALF = 33
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqWrite,
  input  logic [3:0]               reqAddr,
  input  logic [7:0]               reqData,
  output logic                     rspValid,
  output logic [7:0]               rspData,
  output logic                     phi2,
  output logic                     cs0Bar,
  output logic                     readHighWriteLow,
  output logic [3:0]               A,
  output logic [7:0]               Din,
  input  logic [7:0]               Dout,
  output logic [$clog2(DEPTH):0]   fifoCount
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  pokeyReq_t head;
  logic phi_tick, fall_tick, pop;
  logic cs_n, rw_n, rsp_v_n;
  logic [3:0] a_n;
  logic [7:0] din_n, rsp_d_n;
  m_counter #(.MOD(PHI2_HALF)) u_phase (.clk(clk), .clr(clr), .tick(phi_tick));
  pokey_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .clr(clr), .push(reqValid && reqReady),
    .din('{write: reqWrite, addr: reqAddr, data: reqData}),
    .pop(pop), .head(head), .count(fifoCount)
  );
  assign fall_tick = phi_tick & phi2;
  assign reqReady  = fifoCount < CW'(DEPTH);
  // Every bus change lands on a phi2 fall, so outputs are steady through the high phase.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cs_n    = cs0Bar;
    rw_n    = readHighWriteLow;
    a_n     = A;
    din_n   = Din;
    rsp_v_n = 1'b0;
    rsp_d_n = rspData;
    if (fall_tick) begin
      if (state == ACTIVE && readHighWriteLow) begin
        rsp_v_n = 1'b1;
        rsp_d_n = Dout;
      end
      pop     = fifoCount != '0;
      state_n = pop ? ACTIVE : IDLE;
      cs_n    = !pop;
      rw_n    = pop ? !head.write : 1'b1;
      a_n     = pop ? head.addr : A;
      din_n   = pop ? head.data : Din;
    end
  end
  always_ff @(posedge clk)
    if (clr) begin
      state            <= IDLE;
      phi2             <= 1'b0;
      cs0Bar           <= 1'b1;
      readHighWriteLow <= 1'b1;
      A                <= '0;
      Din              <= '0;
      rspValid         <= 1'b0;
      rspData          <= '0;
    end else begin
      state            <= state_n;
      phi2             <= phi2 ^ phi_tick;
      cs0Bar           <= cs_n;
      readHighWriteLow <= rw_n;
      A                <= a_n;
      Din              <= din_n;
      rspValid         <= rsp_v_n;
      rspData          <= rsp_d_n;
    end
endmodule

// File: tb/tb_pokey_bus_sequencer.sv
// tb_pokey_bus_sequencer: directed self-checking bench for pokey_bus_sequencer
module tb_pokey_bus_sequencer;
  import pokey_bus_pkg::*;
  logic clk = 1'b0, clr = 1'b1;
  logic reqValid = 1'b0, reqWrite = 1'b0;
  logic [3:0] reqAddr = '0;
  logic [7:0] reqData = '0;
  logic reqReady, rspValid, phi2, cs0Bar, readHighWriteLow;
  logic [7:0] rspData, Din, Dout;
  logic [3:0] A;
  logic [3:0] fifoCount;
  int cyc = 0, total = 0, bad = 0, rsp_pulses = 0;
  pokey_bus_sequencer #(.DEPTH(8), .PHI2_HALF(33)) dut (
    .clk(clk), .clr(clr), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData), .rspValid(rspValid), .rspData(rspData),
    .phi2(phi2), .cs0Bar(cs0Bar), .readHighWriteLow(readHighWriteLow), .A(A), .Din(Din),
    .Dout(Dout), .fifoCount(fifoCount)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= clr ? 0 : cyc + 1;
  always @(negedge clk) if (rspValid) rsp_pulses++;
  assign Dout = (!cs0Bar && readHighWriteLow) ? (A == RANDOM ? 8'hC3 : {4'h5, A}) : 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = a;
    reqData  = d;
    @(negedge clk);
    reqValid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_phi2", phi2, 0);
    chk("rst_cs", cs0Bar, 1);
    chk("rst_rw", readHighWriteLow, 1);
    chk("rst_A", A, 0);
    chk("rst_Din", Din, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_rspData", rspData, 0);
    chk("rst_count", fifoCount, 0);
    chk("rst_ready", reqReady, 1);
    clr = 1'b0;
    go(32);  chk("phi2_before_rise", phi2, 0);
    go(33);  chk("phi2_rise", phi2, 1);
    go(65);  chk("phi2_before_fall", phi2, 1);
    go(66);  chk("phi2_fall", phi2, 0);
    go(99);  chk("phi2_rise2", phi2, 1);
    go(70);
    push(1'b1, AUDF1, 8'h55);
    chk("wr_count", fifoCount, 1);
    go(131); chk("wr_cs_before", cs0Bar, 1);
    go(132);
    chk("wr_phi2", phi2, 0);
    chk("wr_cs", cs0Bar, 0);
    chk("wr_A", A, 0);
    chk("wr_Din", Din, 8'h55);
    chk("wr_rw", readHighWriteLow, 0);
    chk("wr_popped", fifoCount, 0);
    go(165); chk("wr_cs_mid", cs0Bar, 0);
    go(197); chk("wr_cs_end", cs0Bar, 0);
    go(198);
    chk("wr_cs_release", cs0Bar, 1);
    chk("wr_rw_release", readHighWriteLow, 1);
    chk("wr_Din_hold", Din, 8'h55);
    go(200);
    push(1'b0, RANDOM, 8'h00);
    go(264);
    chk("rd_cs", cs0Bar, 0);
    chk("rd_rw", readHighWriteLow, 1);
    chk("rd_A", A, RANDOM);
    go(329); chk("rd_no_early_rsp", rspValid, 0);
    go(330);
    chk("rd_rspValid", rspValid, 1);
    chk("rd_rspData", rspData, 8'hC3);
    chk("rd_cs_release", cs0Bar, 1);
    go(331);
    chk("rd_rsp_one_cycle", rspValid, 0);
    chk("rd_rspData_hold", rspData, 8'hC3);
    go(335);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    for (int i = 0; i < 9; i++) begin
      reqAddr = 4'(i);
      reqData = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 7) begin
        chk("full_ready", reqReady, 0);
        chk("full_count", fifoCount, 8);
      end
    end
    reqValid = 1'b0;
    chk("full_refused", fifoCount, 8);
    go(395); chk("full_ready_before_pop", reqReady, 0);
    go(396);
    chk("full_ready_after_pop", reqReady, 1);
    chk("full_count_after_pop", fifoCount, 7);
    for (int k = 0; k < 8; k++) begin
      go(396 + 66 * k - 1);
      if (k > 0) chk("burst_cs_gap", cs0Bar, 0);
      go(396 + 66 * k);
      chk("burst_A", A, 32'(k));
      chk("burst_Din", Din, 32'(8'h10 + k));
      chk("burst_cs", cs0Bar, 0);
      chk("burst_rw", readHighWriteLow, 0);
    end
    go(924);
    chk("burst_cs_release", cs0Bar, 1);
    chk("burst_empty", fifoCount, 0);
    go(989);
    push(1'b1, AUDC2, 8'h77);
    chk("fallpush_no_start", cs0Bar, 1);
    chk("fallpush_count", fifoCount, 1);
    go(1056);
    chk("fallpush_cs", cs0Bar, 0);
    chk("fallpush_A", A, AUDC2);
    chk("fallpush_Din", Din, 8'h77);
    chk("fallpush_popped", fifoCount, 0);
    go(1122); chk("fallpush_release", cs0Bar, 1);
    go(1130);
    push(1'b0, AUDC3, 8'h00);
    push(1'b0, AUDF4, 8'h00);
    go(1188);
    chk("clr_rd_cs", cs0Bar, 0);
    chk("clr_rd_A", A, AUDC3);
    chk("clr_rd_count", fifoCount, 1);
    go(1230); chk("clr_phi2_high", phi2, 1);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_cs", cs0Bar, 1);
    chk("clr_phi2", phi2, 0);
    chk("clr_count", fifoCount, 0);
    chk("clr_rspValid", rspValid, 0);
    chk("clr_rw", readHighWriteLow, 1);
    chk("clr_A", A, 0);
    clr = 1'b0;
    repeat (300) @(negedge clk);
    chk("clr_no_rsp_total", rsp_pulses, 1);
    chk("clr_idle_cs", cs0Bar, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
